// File: rtl/ms_uart_wb_arbiter_if.sv
// Wishbone link bundle; the arbiter is the slave on each master link and the master on the slave link.
// The master modport omits err, since the shared slave never raises one.
interface ms_uart_wb_arbiter_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;
    logic        err;

    modport master (output adr, dat_w, sel, cyc, stb, we, input dat_r, ack);
    modport slave  (input adr, dat_w, sel, cyc, stb, we, output dat_r, ack, err);
endinterface

// File: rtl/ms_uart_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of ms_uart_wb: grant one cycle after request, ack/err zero-cycle.
// Owner keeps the bus for its whole cyc; waiting master stalls; unacked strobes end in a TIMEOUT err pulse.
module ms_uart_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ms_uart_wb_arbiter_if.slave         m0,
    ms_uart_wb_arbiter_if.slave         m1,
    ms_uart_wb_arbiter_if.master        s,
    output logic [1:0]                  gnt_o
);

    localparam logic [7:0] LP_TIMEOUT = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic        w_own_stb;
    logic        w_err0;
    logic        w_err1;
    logic        w_err;
    logic        w_to_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Ownership only moves through IDLE, which gives the one-cycle bus-idle gap.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    w_next = r_last ? ST_GNT0 : ST_GNT1;
                end else if (m0.cyc) begin
                    w_next = ST_GNT0;
                end else if (m1.cyc) begin
                    w_next = ST_GNT1;
                end
            end
            ST_GNT0: if (!m0.cyc) w_next = ST_IDLE;
            ST_GNT1: if (!m1.cyc) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_o     = 2'b00;
        w_own_stb = 1'b0;
        s.adr     = m0.adr;
        s.dat_w   = m0.dat_w;
        s.sel     = m0.sel;
        s.we      = 1'b0;
        s.cyc     = 1'b0;
        case (r_state)
            ST_GNT0: begin
                gnt_o     = 2'b01;
                w_own_stb = m0.stb;
                s.we      = m0.we;
                s.cyc     = m0.cyc;
            end
            ST_GNT1: begin
                gnt_o     = 2'b10;
                w_own_stb = m1.stb;
                s.adr     = m1.adr;
                s.dat_w   = m1.dat_w;
                s.sel     = m1.sel;
                s.we      = m1.we;
                s.cyc     = m1.cyc;
            end
            default: ;
        endcase
    end

    // Per-master error terms keep each master's outputs free of the other master's inputs.
    assign w_to_hit = ~s.ack & (r_cnt == LP_TIMEOUT);
    assign w_err0   = gnt_o[0] & m0.stb & w_to_hit;
    assign w_err1   = gnt_o[1] & m1.stb & w_to_hit;
    assign w_err    = w_err0 | w_err1;

    assign s.stb    = w_own_stb & ~w_err;

    assign m0.ack   = s.ack & gnt_o[0];
    assign m1.ack   = s.ack & gnt_o[1];
    assign m0.err   = w_err0;
    assign m1.err   = w_err1;
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (r_state == ST_IDLE && w_next != ST_IDLE) begin
            r_last <= (w_next == ST_GNT1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= 8'd0;
        end else if (r_state == ST_IDLE || s.ack || w_err || !w_own_stb) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ms_uart_wb_arbiter.sv
// Bench for ms_uart_wb_arbiter: two driven masters, a registered-ack slave model and per-master scoreboards.
module tb_ms_uart_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gnt;

    ms_uart_wb_arbiter_if m0_bus ();
    ms_uart_wb_arbiter_if m1_bus ();
    ms_uart_wb_arbiter_if s_bus ();

    ms_uart_wb_arbiter #(.TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .gnt_o (gnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Slave model: registered one-cycle ack pulse, byte-select writes, registered read data.
    logic        r_sack;
    logic [31:0] r_srdat;
    logic [31:0] mem [0:255];
    bit          ack_en    = 1'b1;
    bit          ack_force = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sack  <= 1'b0;
            r_srdat <= 32'h0;
        end else begin
            r_sack <= s_bus.cyc & s_bus.stb & ~r_sack & ack_en;
            if (s_bus.cyc && s_bus.stb && !r_sack && ack_en) begin
                if (s_bus.we) begin
                    for (int b = 0; b < 4; b++)
                        if (s_bus.sel[b]) mem[s_bus.adr[9:2]][8*b +: 8] <= s_bus.dat_w[8*b +: 8];
                end else begin
                    r_srdat <= mem[s_bus.adr[9:2]];
                end
            end
        end
    end

    assign s_bus.ack   = r_sack | ack_force;
    assign s_bus.dat_r = r_srdat;
    assign s_bus.err   = 1'b0;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          chk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    exp_t        mon_e;
    int          mon_m;
    logic [31:0] mon_rd;

    // Every slave ack must reach exactly the owning master and match its oldest expected transfer.
    always @(negedge clk) begin
        if (!rst && s_bus.ack) begin
            n_chk++;
            if ((m0_bus.ack + m1_bus.ack) !== 2'd1) $display("FAIL ack_route: m0_ack=%b m1_ack=%b want exactly one", m0_bus.ack, m1_bus.ack);
            else n_pass++;
            mon_m  = m1_bus.ack ? 1 : 0;
            mon_rd = mon_m ? m1_bus.dat_r : m0_bus.dat_r;
            n_chk++;
            if ((mon_m == 0 && q0.size() == 0) || (mon_m == 1 && q1.size() == 0)) begin
                $display("FAIL sb_unexpected: ack to m%0d with no pending transfer", mon_m);
            end else begin
                n_pass++;
                mon_e = mon_m ? q1.pop_front() : q0.pop_front();
                n_chk++;
                if (gnt !== (mon_m ? 2'b10 : 2'b01)) $display("FAIL sb_gnt: got %b for m%0d", gnt, mon_m);
                else n_pass++;
                n_chk++;
                if (s_bus.adr !== mon_e.adr || s_bus.we !== mon_e.we)
                    $display("FAIL sb_adr_we: got %h/%b want %h/%b", s_bus.adr, s_bus.we, mon_e.adr, mon_e.we);
                else n_pass++;
                if (mon_e.we) begin
                    n_chk++;
                    if (s_bus.dat_w !== mon_e.dat || s_bus.sel !== mon_e.sel)
                        $display("FAIL sb_wdat: got %h/%b want %h/%b", s_bus.dat_w, s_bus.sel, mon_e.dat, mon_e.sel);
                    else n_pass++;
                end else if (mon_e.chk) begin
                    n_chk++;
                    if (mon_rd !== mon_e.dat) $display("FAIL sb_rdat: m%0d got %h want %h", mon_m, mon_rd, mon_e.dat);
                    else n_pass++;
                end
            end
        end
    end

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
            m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
            m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
        end
    endtask

    // dat is the write data, or the expected read data for reads.
    task automatic do_access(input int m, input bit we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel, input bit hold);
        exp_t e;
        bit   got;
        e.we = we; e.adr = adr; e.dat = dat; e.sel = sel; e.chk = 1'b1;
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        set_m(m, 1'b1, 1'b1, we, adr, dat, sel);
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_bus.ack : m1_bus.ack;
        end
        n_chk++;
        if (!got) $display("FAIL ack_wait: m%0d adr %h got no ack within 64 cycles", m, adr);
        else n_pass++;
        @(posedge clk); #1;
        set_m(m, hold, 1'b0, we, adr, dat, sel);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_reset();
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h1, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (gnt !== 2'b00)       $display("FAIL rst_gnt: got %b want 00", gnt); else n_pass++;
        n_chk++; if (s_bus.cyc !== 1'b0)  $display("FAIL rst_s_cyc: got %b want 0", s_bus.cyc); else n_pass++;
        n_chk++; if (s_bus.stb !== 1'b0)  $display("FAIL rst_s_stb: got %b want 0", s_bus.stb); else n_pass++;
        n_chk++; if (s_bus.we !== 1'b0)   $display("FAIL rst_s_we: got %b want 0", s_bus.we); else n_pass++;
        n_chk++; if ({m0_bus.ack, m1_bus.ack} !== 2'b00) $display("FAIL rst_ack: got %b want 00", {m0_bus.ack, m1_bus.ack}); else n_pass++;
        n_chk++; if ({m0_bus.err, m1_bus.err} !== 2'b00) $display("FAIL rst_err: got %b want 00", {m0_bus.err, m1_bus.err}); else n_pass++;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        @(posedge clk); #1;
        do_access(0, 1'b1, 32'h4, 32'h0000_0010, 4'hF, 1'b0);
        @(posedge clk); #1;
        e.we = 1'b0; e.adr = 32'h4; e.dat = 32'h0000_0010; e.sel = 4'hF; e.chk = 1'b1;
        q0.push_back(e);
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        @(posedge clk); #1;
        n_chk++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt); else n_pass++;
        n_chk++; if ({s_bus.cyc, s_bus.stb} !== 2'b11) $display("FAIL single_s_cyc_stb: got %b want 11", {s_bus.cyc, s_bus.stb}); else n_pass++;
        n_chk++; if (m0_bus.ack !== 1'b0) $display("FAIL single_early_ack: got %b want 0", m0_bus.ack); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (m0_bus.ack !== 1'b1) $display("FAIL single_ack: got %b want 1", m0_bus.ack); else n_pass++;
        n_chk++; if (m0_bus.dat_r !== 32'h0000_0010) $display("FAIL single_rdat: got %h want 00000010", m0_bus.dat_r); else n_pass++;
        n_chk++; if (m1_bus.ack !== 1'b0) $display("FAIL single_m1_ack: got %b want 0", m1_bus.ack); else n_pass++;
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 4'hF);
        @(posedge clk); #1;
        n_chk++; if (gnt !== 2'b00 || s_bus.cyc !== 1'b0) $display("FAIL single_release: gnt %b s_cyc %b want 00/0", gnt, s_bus.cyc); else n_pass++;
    endtask

    task automatic test_tie(input string tag);
        @(posedge clk); #1;
        fork
            do_access(0, 1'b1, 32'h10, 32'h1111_0000, 4'hF, 1'b0);
            do_access(1, 1'b1, 32'h14, 32'h0000_2222, 4'hF, 1'b0);
            begin
                @(negedge clk);
                n_chk++; if (gnt !== 2'b00) $display("FAIL %s_pre: gnt %b want 00", tag, gnt); else n_pass++;
                @(negedge clk);
                n_chk++; if (gnt !== 2'b01) $display("FAIL %s_first: gnt %b want 01", tag, gnt); else n_pass++;
                for (int i = 0; i < 32; i++) begin
                    @(negedge clk);
                    if (gnt !== 2'b01) break;
                end
                n_chk++; if (gnt !== 2'b00 || s_bus.cyc !== 1'b0) $display("FAIL %s_gap: gnt %b s_cyc %b want 00/0", tag, gnt, s_bus.cyc); else n_pass++;
                @(negedge clk);
                n_chk++; if (gnt !== 2'b10) $display("FAIL %s_second: gnt %b want 10", tag, gnt); else n_pass++;
            end
        join
    endtask

    task automatic test_hold();
        @(posedge clk); #1;
        fork
            begin
                do_access(1, 1'b1, 32'h100, 32'h0000_00C3, 4'hF, 1'b1);
                do_access(1, 1'b1, 32'h208, 32'h0000_000F, 4'hF, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                do_access(0, 1'b0, 32'h100, 32'h0000_00C3, 4'hF, 1'b0);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                n_chk++; if (gnt !== 2'b10) $display("FAIL hold_first: gnt %b want 10", gnt); else n_pass++;
                for (int i = 0; i < 64; i++) begin
                    @(negedge clk);
                    if (gnt !== 2'b10) break;
                end
                n_chk++; if (gnt !== 2'b00 || s_bus.cyc !== 1'b0) $display("FAIL hold_gap: gnt %b s_cyc %b want 00/0", gnt, s_bus.cyc); else n_pass++;
                @(negedge clk);
                n_chk++; if (gnt !== 2'b01) $display("FAIL hold_m0_gnt: gnt %b want 01", gnt); else n_pass++;
            end
        join
    endtask

    task automatic test_timeout();
        exp_t e;
        @(posedge clk); #1;
        ack_en = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        @(posedge clk);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            n_chk++; if (m0_bus.err !== (k == 4)) $display("FAIL to_err G+%0d: got %b want %b", k, m0_bus.err, (k == 4)); else n_pass++;
            n_chk++; if (s_bus.stb !== (k != 4)) $display("FAIL to_stb G+%0d: got %b want %b", k, s_bus.stb, (k != 4)); else n_pass++;
            n_chk++; if ({m0_bus.ack, m1_bus.err} !== 2'b00) $display("FAIL to_quiet G+%0d: m0_ack/m1_err %b want 00", k, {m0_bus.ack, m1_bus.err}); else n_pass++;
        end
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
        @(posedge clk); #1;
        e.we = 1'b0; e.adr = 32'h8; e.dat = 32'h0; e.sel = 4'hF; e.chk = 1'b0;
        q0.push_back(e);
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        ack_force = 1'b1;
        @(negedge clk);
        n_chk++; if (m0_bus.ack !== 1'b1) $display("FAIL to_ack_wins_ack: got %b want 1", m0_bus.ack); else n_pass++;
        n_chk++; if (m0_bus.err !== 1'b0) $display("FAIL to_ack_wins_err: got %b want 0", m0_bus.err); else n_pass++;
        @(posedge clk); #1;
        ack_force = 1'b0;
        ack_en    = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        ack_en = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b1, 32'hC, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk);
        @(negedge clk);
        n_chk++; if (gnt !== 2'b01) $display("FAIL rmid_pre_gnt: got %b want 01", gnt); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (gnt !== 2'b00) $display("FAIL rmid_gnt: got %b want 00", gnt); else n_pass++;
        n_chk++; if ({s_bus.cyc, s_bus.stb} !== 2'b00) $display("FAIL rmid_s_cyc_stb: got %b want 00", {s_bus.cyc, s_bus.stb}); else n_pass++;
        n_chk++; if ({m0_bus.ack, m1_bus.ack} !== 2'b00) $display("FAIL rmid_ack: got %b want 00", {m0_bus.ack, m1_bus.ack}); else n_pass++;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        ack_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        test_tie("tie_after_rst");
    endtask

    task automatic test_isolation();
        @(posedge clk); #1;
        fork
            do_access(1, 1'b1, 32'h0, 32'hA5C3_1E77, 4'b0101, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                n_chk++; if (gnt !== 2'b10) $display("FAIL iso_gnt: got %b want 10", gnt); else n_pass++;
                n_chk++; if (s_bus.dat_w !== 32'hA5C3_1E77) $display("FAIL iso_dat: got %h want a5c31e77", s_bus.dat_w); else n_pass++;
                n_chk++; if (s_bus.sel !== 4'b0101 || s_bus.we !== 1'b1) $display("FAIL iso_sel_we: got %b/%b want 0101/1", s_bus.sel, s_bus.we); else n_pass++;
                @(negedge clk);
                n_chk++; if ({m0_bus.ack, m1_bus.ack} !== 2'b01) $display("FAIL iso_ack: m0/m1 %b want 01", {m0_bus.ack, m1_bus.ack}); else n_pass++;
            end
        join
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        test_reset();
        test_single();
        reset_dut();
        test_tie("tie1");
        test_tie("tie2");
        test_hold();
        test_timeout();
        test_reset_mid();
        test_isolation();
        repeat (3) @(posedge clk);
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) $display("FAIL sb_leftover: q0 %0d q1 %0d want 0/0", q0.size(), q1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
